mole_round_sequencer: RTL and testbench

//  Game-round scheduler for the whack-a-mole datapath. Runs start countdown, then

---
 rtl/mole_round_sequencer_pkg.sv | 20 ++
 rtl/mole_round_sequencer_if.sv | 23 ++
 rtl/mole_round_sequencer_ms_tick_gen.sv | 16 +
 rtl/mole_round_sequencer.sv | 90 +++++++++
 tb/tb_mole_round_sequencer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mole_round_sequencer_pkg.sv
// mole_round_sequencer_pkg: state encoding, difficulty codes and mole on-window defaults
package mole_round_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_SPAWN     = 3'd2,
    S_SHOW      = 3'd3,
    S_GAP       = 3'd4,
    S_GAMEOVER  = 3'd5
  } state_t;
  localparam logic [3:0] DIFF_MED  = 4'd2;
  localparam logic [3:0] DIFF_HARD = 4'd3;
  localparam int DEF_ON_EASY_MS = 2000;
  localparam int DEF_ON_MED_MS  = 1200;
  localparam int DEF_ON_HARD_MS = 700;
  // Any code other than medium or hard, including 1, plays at easy timing.
  function automatic logic [11:0] on_ms(input logic [3:0] d, input logic [11:0] easy, med, hard);
    return d == DIFF_HARD ? hard : d == DIFF_MED ? med : easy;
  endfunction
endpackage

// File: rtl/mole_round_sequencer_if.sv
// mole_round_sequencer_if: game controls in, round status out
interface mole_round_sequencer_if #(parameter int SCORE_W = 12);
  logic               start;
  logic               abort;
  logic [3:0]         difficulty;
  logic               hit;
  logic               new_mole;
  logic               mole_active;
  logic [11:0]        countdown_ms;
  logic [7:0]         moles_left;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic               game_over;
  logic [2:0]         state_o;
  modport master (
    output start, abort, difficulty, hit,
    input  new_mole, mole_active, countdown_ms, moles_left, score, high_score, game_over, state_o
  );
  modport slave (
    input  start, abort, difficulty, hit,
    output new_mole, mole_active, countdown_ms, moles_left, score, high_score, game_over, state_o
  );
endinterface

// File: rtl/mole_round_sequencer_ms_tick_gen.sv
// ms_tick_gen: millisecond prescaler, restartable so every state starts on a whole-ms boundary
module ms_tick_gen #(parameter int CLKS_PER_MS = 50000) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(CLKS_PER_MS + 1);
  logic [CW-1:0] cnt;
  // tick depends only on the count so the FSM can use it without a loop through clr
  assign tick = cnt == CW'(CLKS_PER_MS - 1);
  // count clk cycles, wrapping on each tick and restarting on clr
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/mole_round_sequencer.sv
// mole_round_sequencer: countdown, mole spawn/show/gap sequencing, scoring and high score
module mole_round_sequencer import mole_round_sequencer_pkg::*; #(
  parameter int CLKS_PER_MS  = 50000,
  parameter int NUM_MOLES    = 30,
  parameter int COUNTDOWN_MS = 3000,
  parameter int GAP_MS       = 250,
  parameter int SCORE_W      = 12,
  parameter int ON_EASY_MS   = DEF_ON_EASY_MS,
  parameter int ON_MED_MS    = DEF_ON_MED_MS,
  parameter int ON_HARD_MS   = DEF_ON_HARD_MS
) (
  input logic clk,
  input logic rst_n,
  mole_round_sequencer_if.slave bus
);
  state_t state, state_n;
  logic tick, expire, enter, launch;
  logic [11:0] ms_left, ms_left_n, dur, countdown_ms;
  logic [7:0] moles_left;
  logic [3:0] diff_lat;
  logic [SCORE_W-1:0] score, high_score;
  logic new_mole, mole_active, game_over;

  ms_tick_gen #(.CLKS_PER_MS(CLKS_PER_MS)) u_tick (.clk(clk), .rst_n(rst_n), .clr(enter), .tick(tick));

  assign expire = tick && ms_left <= 12'd1;
  assign enter  = state_n != state;
  assign launch = enter && state_n == S_COUNTDOWN;
  assign dur = state_n == S_COUNTDOWN ? 12'(COUNTDOWN_MS) :
               state_n == S_SHOW      ? on_ms(diff_lat, 12'(ON_EASY_MS), 12'(ON_MED_MS), 12'(ON_HARD_MS)) :
               state_n == S_GAP       ? 12'(GAP_MS) : 12'd0;
  assign ms_left_n = enter ? dur : (tick && ms_left != 12'd0) ? ms_left - 12'd1 : ms_left;

  assign bus.new_mole     = new_mole;
  assign bus.mole_active  = mole_active;
  assign bus.countdown_ms = countdown_ms;
  assign bus.moles_left   = moles_left;
  assign bus.score        = score;
  assign bus.high_score   = high_score;
  assign bus.game_over    = game_over;
  assign bus.state_o      = state;

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;

  // next state; abort overrides everything, including start
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_GAMEOVER: state_n = bus.start ? S_COUNTDOWN : state;
      S_COUNTDOWN:        state_n = expire ? S_SPAWN : state;
      S_SPAWN:            state_n = S_SHOW;
      S_SHOW:             state_n = (bus.hit || expire) ? S_GAP : state;
      S_GAP:              state_n = expire ? (moles_left == 8'd0 ? S_GAMEOVER : S_SPAWN) : state;
      default:            state_n = S_IDLE;
    endcase
    if (bus.abort) state_n = S_IDLE;
  end

  // ms timer, registered outputs, game setup, mole count and scoring
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ms_left      <= '0;
      countdown_ms <= '0;
      new_mole     <= 1'b0;
      mole_active  <= 1'b0;
      game_over    <= 1'b0;
      diff_lat     <= '0;
      moles_left   <= '0;
      score        <= '0;
      high_score   <= '0;
    end else begin
      ms_left      <= ms_left_n;
      countdown_ms <= state_n == S_COUNTDOWN ? ms_left_n : 12'd0;
      new_mole     <= state_n == S_SPAWN;
      mole_active  <= state_n == S_SHOW;
      game_over    <= state_n == S_GAMEOVER;
      if (launch) begin
        diff_lat   <= bus.difficulty;
        moles_left <= 8'(NUM_MOLES);
        score      <= '0;
      end else begin
        if (enter && state_n == S_SPAWN) moles_left <= moles_left - 8'd1;
        if (state == S_SHOW && bus.hit && !bus.abort && score != '1) score <= score + 1'b1;
      end
      if (enter && state_n == S_GAMEOVER && score > high_score) high_score <= score;
    end
endmodule

// File: tb/tb_mole_round_sequencer.sv
// tb_mole_round_sequencer: directed scenario tests of the mole round sequencer
module tb_mole_round_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  mole_round_sequencer_if #(.SCORE_W(12)) bus ();

  mole_round_sequencer #(
    .CLKS_PER_MS(10), .NUM_MOLES(3), .COUNTDOWN_MS(3), .GAP_MS(2), .SCORE_W(12),
    .ON_EASY_MS(20), .ON_MED_MS(12), .ON_HARD_MS(7)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // play the rest of a game; a window gets hit on its hit_at-th cycle (0 = never)
  task automatic play(input int hit_at, output int pulses, output int win[3], output bit done);
    int run;
    run = 0;
    pulses = 0;
    done = 1'b0;
    win = '{0, 0, 0};
    for (int c = 0; c < 3000 && !done; c++) begin
      step();
      bus.hit = 1'b0;
      if (bus.new_mole) pulses++;
      if (bus.mole_active) begin
        run++;
        if (run == hit_at) bus.hit = 1'b1;
      end else if (run > 0) begin
        if (pulses >= 1 && pulses <= 3) win[pulses-1] = run;
        run = 0;
      end
      if (bus.game_over) done = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.state_o !== 3'd0) begin bad++; $display("FAIL rst_state got %0d want 0", bus.state_o); end
    total++; if (bus.score !== 12'd0 || bus.high_score !== 12'd0) begin bad++; $display("FAIL rst_score got %0d/%0d want 0/0", bus.score, bus.high_score); end
    rst_n = 1'b1;
    repeat (3) step();
    total++; if (bus.state_o !== 3'd0) begin bad++; $display("FAIL idle_state got %0d want 0", bus.state_o); end
    total++; if ({bus.new_mole, bus.mole_active, bus.game_over} !== 3'b000) begin bad++; $display("FAIL idle_flags got %b want 000", {bus.new_mole, bus.mole_active, bus.game_over}); end
    total++; if (bus.countdown_ms !== 12'd0 || bus.moles_left !== 8'd0) begin bad++; $display("FAIL idle_counts got %0d/%0d want 0/0", bus.countdown_ms, bus.moles_left); end
  endtask

  task automatic test_countdown();
    bus.difficulty = 4'd3;
    pulse_start();
    total++; if (bus.state_o !== 3'd1 || bus.countdown_ms !== 12'd3) begin bad++; $display("FAIL cd_entry got state %0d cd %0d want 1/3", bus.state_o, bus.countdown_ms); end
    total++; if (bus.moles_left !== 8'd3) begin bad++; $display("FAIL cd_moles got %0d want 3", bus.moles_left); end
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 9) begin total++; if (bus.countdown_ms !== 12'd3) begin bad++; $display("FAIL cd_9 got %0d want 3", bus.countdown_ms); end end
      if (i == 10) begin total++; if (bus.countdown_ms !== 12'd2) begin bad++; $display("FAIL cd_10 got %0d want 2", bus.countdown_ms); end end
      if (i == 20) begin total++; if (bus.countdown_ms !== 12'd1) begin bad++; $display("FAIL cd_20 got %0d want 1", bus.countdown_ms); end end
    end
    total++; if (bus.countdown_ms !== 12'd0 || bus.state_o !== 3'd2) begin bad++; $display("FAIL cd_30 got cd %0d state %0d want 0/2", bus.countdown_ms, bus.state_o); end
    total++; if (bus.new_mole !== 1'b1 || bus.moles_left !== 8'd2) begin bad++; $display("FAIL spawn got nm %b left %0d want 1/2", bus.new_mole, bus.moles_left); end
    step();
    total++; if (bus.new_mole !== 1'b0 || bus.mole_active !== 1'b1) begin bad++; $display("FAIL show_entry got nm %b act %b want 0/1", bus.new_mole, bus.mole_active); end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    total++; if (bus.state_o !== 3'd0) begin bad++; $display("FAIL abort_idle got %0d want 0", bus.state_o); end
  endtask

  task automatic test_hard_no_hits();
    int pulses;
    int win[3];
    bit done;
    bus.difficulty = 4'd3;
    pulse_start();
    play(0, pulses, win, done);
    total++; if (!done) begin bad++; $display("FAIL hard_done got 0 want 1 (timeout)"); end
    total++; if (pulses !== 3) begin bad++; $display("FAIL hard_pulses got %0d want 3", pulses); end
    for (int m = 0; m < 3; m++) begin
      total++; if (win[m] !== 70) begin bad++; $display("FAIL hard_win%0d got %0d want 70", m, win[m]); end
    end
    total++; if (bus.state_o !== 3'd5 || bus.score !== 12'd0 || bus.high_score !== 12'd0) begin bad++; $display("FAIL hard_end got state %0d score %0d high %0d want 5/0/0", bus.state_o, bus.score, bus.high_score); end
    total++; if (bus.moles_left !== 8'd0) begin bad++; $display("FAIL hard_left got %0d want 0", bus.moles_left); end
  endtask

  task automatic test_easy_hits();
    int pulses;
    int win[3];
    bit done;
    bus.difficulty = 4'd1;
    pulse_start();
    play(5, pulses, win, done);
    total++; if (!done || pulses !== 3) begin bad++; $display("FAIL hits_run got done %0d pulses %0d want 1/3", done, pulses); end
    for (int m = 0; m < 3; m++) begin
      total++; if (win[m] !== 5) begin bad++; $display("FAIL hits_win%0d got %0d want 5", m, win[m]); end
    end
    total++; if (bus.score !== 12'd3 || bus.high_score !== 12'd3) begin bad++; $display("FAIL hits_score got %0d/%0d want 3/3", bus.score, bus.high_score); end
  endtask

  task automatic test_hit_boundaries();
    int pulses;
    int win[3];
    int run;
    bit done;
    bus.difficulty = 4'd2;
    pulse_start();
    total++; if (bus.score !== 12'd0) begin bad++; $display("FAIL restart_clear got %0d want 0", bus.score); end
    step();
    bus.hit = 1'b1;
    step();
    bus.hit = 1'b0;
    total++; if (bus.score !== 12'd0) begin bad++; $display("FAIL hit_in_cd got %0d want 0", bus.score); end
    for (int c = 0; c < 400 && !bus.mole_active; c++) step();
    run = 0;
    for (int c = 0; c < 300 && bus.mole_active; c++) begin
      run++;
      if (run == 120) bus.hit = 1'b1;
      step();
      bus.hit = 1'b0;
    end
    total++; if (run !== 120) begin bad++; $display("FAIL expiry_win got %0d want 120", run); end
    total++; if (bus.score !== 12'd1 || bus.state_o !== 3'd4) begin bad++; $display("FAIL expiry_hit got score %0d state %0d want 1/4", bus.score, bus.state_o); end
    bus.hit = 1'b1;
    step();
    bus.hit = 1'b0;
    total++; if (bus.score !== 12'd1) begin bad++; $display("FAIL hit_in_gap got %0d want 1", bus.score); end
    play(0, pulses, win, done);
    total++; if (!done || bus.score !== 12'd1 || bus.high_score !== 12'd3) begin bad++; $display("FAIL low_game got done %0d score %0d high %0d want 1/1/3", done, bus.score, bus.high_score); end
  endtask

  task automatic test_abort_restart();
    int pulses;
    int run;
    bus.difficulty = 4'd3;
    pulse_start();
    pulses = 0;
    run = 0;
    for (int c = 0; c < 1000 && !(pulses == 2 && run == 3); c++) begin
      step();
      bus.hit = 1'b0;
      if (bus.new_mole) pulses++;
      if (bus.mole_active) begin
        run++;
        if (pulses == 1 && run == 5) bus.hit = 1'b1;
      end else run = 0;
    end
    total++; if (pulses !== 2 || run !== 3) begin bad++; $display("FAIL abort_reach got %0d/%0d want 2/3", pulses, run); end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    total++; if (bus.state_o !== 3'd0 || bus.mole_active !== 1'b0) begin bad++; $display("FAIL abort_show got state %0d act %b want 0/0", bus.state_o, bus.mole_active); end
    total++; if (bus.score !== 12'd1 || bus.high_score !== 12'd3) begin bad++; $display("FAIL abort_scores got %0d/%0d want 1/3", bus.score, bus.high_score); end
    step();
    pulse_start();
    total++; if (bus.score !== 12'd0 || bus.state_o !== 3'd1 || bus.moles_left !== 8'd3) begin bad++; $display("FAIL abort_restart got score %0d state %0d left %0d want 0/1/3", bus.score, bus.state_o, bus.moles_left); end
    repeat (14) step();
    pulse_start();
    total++; if (bus.state_o !== 3'd1 || bus.countdown_ms !== 12'd2) begin bad++; $display("FAIL start_in_cd got state %0d cd %0d want 1/2", bus.state_o, bus.countdown_ms); end
    bus.abort = 1'b1;
    bus.start = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    total++; if (bus.state_o !== 3'd0) begin bad++; $display("FAIL abort_beats_start got %0d want 0", bus.state_o); end
  endtask

  task automatic test_difficulty_latch();
    int pulses;
    int win[3];
    bit done;
    bus.difficulty = 4'd7;
    pulse_start();
    repeat (5) step();
    bus.difficulty = 4'd3;
    play(0, pulses, win, done);
    total++; if (!done || pulses !== 3) begin bad++; $display("FAIL latch_run got done %0d pulses %0d want 1/3", done, pulses); end
    for (int m = 0; m < 3; m++) begin
      total++; if (win[m] !== 200) begin bad++; $display("FAIL latch_win%0d got %0d want 200", m, win[m]); end
    end
    total++; if (bus.score !== 12'd0 || bus.high_score !== 12'd3) begin bad++; $display("FAIL latch_scores got %0d/%0d want 0/3", bus.score, bus.high_score); end
  endtask

  task automatic test_async_reset();
    bus.difficulty = 4'd3;
    pulse_start();
    for (int c = 0; c < 400 && !bus.mole_active; c++) step();
    total++; if (bus.mole_active !== 1'b1) begin bad++; $display("FAIL arst_reach got %b want 1", bus.mole_active); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.state_o !== 3'd0 || bus.mole_active !== 1'b0 || bus.moles_left !== 8'd0) begin bad++; $display("FAIL arst_state got state %0d act %b left %0d want 0/0/0", bus.state_o, bus.mole_active, bus.moles_left); end
    total++; if (bus.high_score !== 12'd0) begin bad++; $display("FAIL arst_high got %0d want 0", bus.high_score); end
    #10 rst_n = 1'b1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.hit = 1'b0;
    bus.difficulty = 4'd0;
    test_reset();
    test_countdown();
    test_hard_no_hits();
    test_easy_hits();
    test_hit_boundaries();
    test_abort_restart();
    test_difficulty_latch();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
